// File: rtl/minisrc_pkg.sv
// Mini SRC shared encodings: opcodes, control-step enum and opcode classification.
// Imported by both the control unit and the datapath.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_ALUI, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } op_class_t;

  // Undefined opcodes fall into CL_NOP.
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:                return CL_ALUI;
      OP_DIV, OP_MUL:                          return CL_MULDIV;
      OP_NEG, OP_NOT:                          return CL_UNARY;
      OP_LD:                                   return CL_LD;
      OP_LDI:                                  return CL_LDI;
      OP_ST:                                   return CL_ST;
      OP_BR:                                   return CL_BR;
      OP_JR:                                   return CL_JR;
      OP_JAL:                                  return CL_JAL;
      OP_IN:                                   return CL_IN;
      OP_OUT:                                  return CL_OUT;
      OP_MFHI:                                 return CL_MFHI;
      OP_MFLO:                                 return CL_MFLO;
      OP_HALT:                                 return CL_HALT;
      default:                                 return CL_NOP;
    endcase
  endfunction

  // Final execute step of each class; the instruction boundary follows it.
  function automatic step_t last_step(input op_class_t c);
    case (c)
      CL_ALU, CL_ALUI, CL_LDI:   return T5;
      CL_MULDIV, CL_ST, CL_BR:   return T6;
      CL_UNARY, CL_JAL:          return T4;
      CL_LD:                     return T7;
      default:                   return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/condition/halt request in, all control strobes out.
interface control_unit_if;
  logic [31:0] IR;
  logic BranchOut, Stop;
  logic Run, Clear_dp;
  logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout, RINout, OutPortOut;
  logic PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn;
  logic Gra, Grb, Grc;
  logic Read, Write, IncPC;
  logic ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT;

  modport master (
    input  IR, BranchOut, Stop,
    output Run, Clear_dp,
    output PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout, RINout, OutPortOut,
    output PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn,
    output Gra, Grb, Grc, Read, Write, IncPC,
    output ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
  );

  modport slave (
    output IR, BranchOut, Stop,
    input  Run, Clear_dp,
    input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout, RINout, OutPortOut,
    input  PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn,
    input  Gra, Grb, Grc, Read, Write, IncPC,
    input  ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: step counter + run/halt flag, Moore decode of
// (step, opcode) into every datapath strobe.
import minisrc_pkg::*;

module control_unit (
  input  logic     Clock,
  input  logic     Clear,
  control_unit_if.master cu
);

  step_t     state, nxt;
  op_class_t cls;
  logic [4:0] op;
  logic      alu_en, add_en;

  assign op  = cu.IR[31:27];
  assign cls = op_class(op);
  assign cu.Clear_dp = Clear;

  always_ff @(posedge Clock) begin
    if (Clear) state <= RST;
    else       state <= nxt;
  end

  // IR is only consulted from T3 on; fetch steps are opcode-independent.
  always_comb begin
    nxt = state;
    case (state)
      RST:  nxt = T0;
      T0:   nxt = T1;
      T1:   nxt = T2;
      T2:   nxt = T3;
      T3, T4, T5, T6, T7: begin
        if (cls == CL_HALT)               nxt = HALT;
        else if (state == last_step(cls)) nxt = cu.Stop ? HALT : T0;
        else                              nxt = step_t'(4'(state) + 4'd1);
      end
      HALT: nxt = HALT;
      default: nxt = RST;
    endcase
  end

  always_comb begin
    cu.Run = (state != HALT);
    cu.PCout = 1'b0; cu.Zlowout = 1'b0; cu.Zhighout = 1'b0; cu.MDRout = 1'b0;
    cu.LOout = 1'b0; cu.HIout = 1'b0; cu.Cout = 1'b0; cu.BAout = 1'b0;
    cu.Rout = 1'b0; cu.RINout = 1'b0; cu.OutPortOut = 1'b0;
    cu.PCin = 1'b0; cu.IRin = 1'b0; cu.Yin = 1'b0; cu.Zin = 1'b0;
    cu.MARin = 1'b0; cu.MDRin = 1'b0; cu.LOin = 1'b0; cu.HIin = 1'b0;
    cu.Rin = 1'b0; cu.RAin = 1'b0; cu.CONin = 1'b0; cu.OutPortIn = 1'b0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0;
    cu.Read = 1'b0; cu.Write = 1'b0; cu.IncPC = 1'b0;
    cu.ADD = 1'b0; cu.SUB = 1'b0; cu.MUL = 1'b0; cu.DIV = 1'b0;
    cu.SHR = 1'b0; cu.SHRA = 1'b0; cu.SHL = 1'b0; cu.ROR = 1'b0;
    cu.ROL = 1'b0; cu.AND = 1'b0; cu.OR = 1'b0; cu.NEG = 1'b0; cu.NOT = 1'b0;
    alu_en = 1'b0;
    add_en = 1'b0;

    case (state)
      T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1; end
      T1: begin cu.Zlowout = 1'b1; cu.PCin = 1'b1; cu.Read = 1'b1; cu.MDRin = 1'b1; end
      T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
      T3: case (cls)
        CL_ALU, CL_ALUI:     begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
        CL_MULDIV:           begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
        CL_UNARY:            begin cu.Grb = 1'b1; cu.Rout = 1'b1; alu_en = 1'b1; cu.Zin = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
        CL_BR:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
        CL_JR:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
        CL_JAL:              begin cu.PCout = 1'b1; cu.RAin = 1'b1; end
        CL_IN:               begin cu.RINout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        CL_OUT:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortIn = 1'b1; end
        CL_MFHI:             begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        CL_MFLO:             begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        default: ;
      endcase
      T4: case (cls)
        CL_ALU:              begin cu.Grc = 1'b1; cu.Rout = 1'b1; alu_en = 1'b1; cu.Zin = 1'b1; end
        CL_ALUI:             begin cu.Cout = 1'b1; alu_en = 1'b1; cu.Zin = 1'b1; end
        CL_MULDIV:           begin cu.Grb = 1'b1; cu.Rout = 1'b1; alu_en = 1'b1; cu.Zin = 1'b1; end
        CL_UNARY:            begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin cu.Cout = 1'b1; add_en = 1'b1; cu.Zin = 1'b1; end
        CL_BR:               begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
        CL_JAL:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
        default: ;
      endcase
      T5: case (cls)
        CL_ALU, CL_ALUI, CL_LDI: begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        CL_MULDIV:           begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
        CL_LD, CL_ST:        begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
        CL_BR:               begin cu.Cout = 1'b1; add_en = 1'b1; cu.Zin = 1'b1; end
        default: ;
      endcase
      T6: case (cls)
        CL_MULDIV:           begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
        CL_LD:               begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
        CL_ST:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Write = 1'b1; end
        CL_BR:               begin cu.Zlowout = cu.BranchOut; cu.PCin = cu.BranchOut; end
        default: ;
      endcase
      T7: if (cls == CL_LD) begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
      default: ;
    endcase

    // Immediate forms reuse the register-form ALU select.
    if (alu_en) begin
      case (op)
        OP_ADD, OP_ADDI: cu.ADD  = 1'b1;
        OP_SUB:          cu.SUB  = 1'b1;
        OP_AND, OP_ANDI: cu.AND  = 1'b1;
        OP_OR,  OP_ORI:  cu.OR   = 1'b1;
        OP_ROR:          cu.ROR  = 1'b1;
        OP_ROL:          cu.ROL  = 1'b1;
        OP_SHR:          cu.SHR  = 1'b1;
        OP_SHRA:         cu.SHRA = 1'b1;
        OP_SHL:          cu.SHL  = 1'b1;
        OP_MUL:          cu.MUL  = 1'b1;
        OP_DIV:          cu.DIV  = 1'b1;
        OP_NEG:          cu.NEG  = 1'b1;
        OP_NOT:          cu.NOT  = 1'b1;
        default: ;
      endcase
    end
    if (add_en) cu.ADD = 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step strobe vectors against hand-derived tables.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  control_unit_if bus();
  control_unit dut (.Clock(clk), .Clear(clr), .cu(bus));

  always #5 clk = ~clk;

  localparam logic [41:0] PCOUT = 42'd1 << 41, ZLOW  = 42'd1 << 40, ZHIGH = 42'd1 << 39;
  localparam logic [41:0] MDROUT = 42'd1 << 38, COUT = 42'd1 << 35, BAOUT = 42'd1 << 34;
  localparam logic [41:0] ROUT  = 42'd1 << 33;
  localparam logic [41:0] PCIN  = 42'd1 << 30, IRIN  = 42'd1 << 29, YIN   = 42'd1 << 28;
  localparam logic [41:0] ZIN   = 42'd1 << 27, MARIN = 42'd1 << 26, MDRIN = 42'd1 << 25;
  localparam logic [41:0] LOIN  = 42'd1 << 24, HIIN  = 42'd1 << 23, RIN   = 42'd1 << 22;
  localparam logic [41:0] RAIN  = 42'd1 << 21, CONIN = 42'd1 << 20;
  localparam logic [41:0] GRA   = 42'd1 << 18, GRB   = 42'd1 << 17, GRC   = 42'd1 << 16;
  localparam logic [41:0] READ  = 42'd1 << 15, WRITE = 42'd1 << 14, INCPC = 42'd1 << 13;
  localparam logic [41:0] ADD   = 42'd1 << 12, MUL   = 42'd1 << 10;

  localparam logic [41:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [41:0] F1 = ZLOW | PCIN | READ | MDRIN;
  localparam logic [41:0] F2 = MDROUT | IRIN;

  function automatic logic [41:0] strobes();
    return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.LOout, bus.HIout,
            bus.Cout, bus.BAout, bus.Rout, bus.RINout, bus.OutPortOut,
            bus.PCin, bus.IRin, bus.Yin, bus.Zin, bus.MARin, bus.MDRin, bus.LOin,
            bus.HIin, bus.Rin, bus.RAin, bus.CONin, bus.OutPortIn,
            bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.Write, bus.IncPC,
            bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHRA, bus.SHL,
            bus.ROR, bus.ROL, bus.AND, bus.OR, bus.NEG, bus.NOT};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT sitting in T0 of a fresh instruction.
  task automatic go_t0(input logic [31:0] ir);
    clr = 1'b1; bus.Stop = 1'b0; bus.BranchOut = 1'b0; bus.IR = ir;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1; bus.IR = 32'h0; bus.Stop = 1'b0; bus.BranchOut = 1'b0;
    tick(); tick();
    checks++; if (strobes() !== 42'd0) begin errors++; $display("FAIL reset_strobes got %h want 0", strobes()); end
    checks++; if (bus.Run !== 1'b1) begin errors++; $display("FAIL reset_run got %b want 1", bus.Run); end
    checks++; if (bus.Clear_dp !== 1'b1) begin errors++; $display("FAIL reset_clear_dp got %b want 1", bus.Clear_dp); end
    clr = 1'b0;
    #1;
    checks++; if (bus.Clear_dp !== 1'b0) begin errors++; $display("FAIL release_clear_dp got %b want 0", bus.Clear_dp); end
    checks++; if (strobes() !== 42'd0) begin errors++; $display("FAIL rst_hold got %h want 0", strobes()); end
    tick();
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL first_t0 got %h want %h", strobes(), F0); end
    checks++; if (bus.Run !== 1'b1) begin errors++; $display("FAIL t0_run got %b want 1", bus.Run); end
  endtask

  task automatic test_add();
    logic [41:0] e [6];
    e = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ADD | ZIN, ZLOW | GRA | RIN};
    go_t0(32'h1A9A_0000);
    for (int i = 0; i < 6; i++) begin
      checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL add_step%0d got %h want %h", i, strobes(), e[i]); end
      tick();
    end
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL add_next_t0 got %h want %h", strobes(), F0); end
  endtask

  task automatic test_addi();
    logic [41:0] e [6];
    e = '{F0, F1, F2, GRB | ROUT | YIN, COUT | ADD | ZIN, ZLOW | GRA | RIN};
    go_t0(32'h6000_0000);
    for (int i = 0; i < 6; i++) begin
      checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL addi_step%0d got %h want %h", i, strobes(), e[i]); end
      tick();
    end
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL addi_next_t0 got %h want %h", strobes(), F0); end
  endtask

  task automatic test_ld();
    logic [41:0] e [8];
    int reads = 0;
    e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ADD | ZIN, ZLOW | MARIN, READ | MDRIN, MDROUT | GRA | RIN};
    go_t0(32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL ld_step%0d got %h want %h", i, strobes(), e[i]); end
      if (bus.Read === 1'b1) reads++;
      tick();
    end
    checks++; if (reads !== 2) begin errors++; $display("FAIL ld_read_count got %0d want 2", reads); end
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL ld_next_t0 got %h want %h", strobes(), F0); end
  endtask

  task automatic test_br();
    logic [41:0] e [7];
    for (int b = 0; b < 2; b++) begin
      e = '{F0, F1, F2, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ADD | ZIN, (b == 1) ? (ZLOW | PCIN) : 42'd0};
      go_t0(32'h9800_0000);
      for (int i = 0; i < 7; i++) begin
        // Hold the flag opposite to its final value until T6 so early use shows up.
        bus.BranchOut = (i == 6) ? b[0] : ~b[0];
        #1;
        checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL br%0d_step%0d got %h want %h", b, i, strobes(), e[i]); end
        tick();
      end
      checks++; if (strobes() !== F0) begin errors++; $display("FAIL br%0d_next_t0 got %h want %h", b, strobes(), F0); end
    end
  endtask

  task automatic test_mul();
    logic [41:0] e [7];
    e = '{F0, F1, F2, GRA | ROUT | YIN, GRB | ROUT | MUL | ZIN, ZLOW | LOIN, ZHIGH | HIIN};
    go_t0(32'h8000_0000);
    for (int i = 0; i < 7; i++) begin
      checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL mul_step%0d got %h want %h", i, strobes(), e[i]); end
      checks++; if ((bus.LOin & bus.HIin) !== 1'b0) begin errors++; $display("FAIL mul_lo_hi_overlap step%0d got 1 want 0", i); end
      tick();
    end
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL mul_next_t0 got %h want %h", strobes(), F0); end
  endtask

  task automatic test_short();
    logic [41:0] e [5];
    // undefined opcode 11111 behaves as nop
    go_t0(32'hF800_0000);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL undef_next_t0 got %h want %h", strobes(), F0); end
    e = '{F0, F1, F2, PCOUT | RAIN, GRA | ROUT | PCIN};
    go_t0(32'hA000_0000);
    for (int i = 0; i < 5; i++) begin
      checks++; if (strobes() !== e[i]) begin errors++; $display("FAIL jal_step%0d got %h want %h", i, strobes(), e[i]); end
      tick();
    end
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL jal_next_t0 got %h want %h", strobes(), F0); end
  endtask

  task automatic test_halt();
    go_t0(32'hD800_0000);
    tick(); tick(); tick();
    checks++; if (strobes() !== 42'd0 || bus.Run !== 1'b1) begin errors++; $display("FAIL halt_t3 got %h run %b want 0 run 1", strobes(), bus.Run); end
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.Run !== 1'b0 || strobes() !== 42'd0) begin errors++; $display("FAIL halted_c%0d run %b strobes %h want run 0 strobes 0", i, bus.Run, strobes()); end
      tick();
    end
    clr = 1'b1;
    tick();
    checks++; if (bus.Run !== 1'b1 || strobes() !== 42'd0) begin errors++; $display("FAIL halt_clear run %b strobes %h want run 1 strobes 0", bus.Run, strobes()); end
    clr = 1'b0;
    tick();
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL halt_restart got %h want %h", strobes(), F0); end
  endtask

  task automatic test_stop();
    go_t0(32'h1A9A_0000);
    tick(); tick(); tick();
    bus.Stop = 1'b1;
    tick();
    checks++; if (bus.Run !== 1'b1 || strobes() !== (GRC | ROUT | ADD | ZIN)) begin errors++; $display("FAIL stop_t4 run %b strobes %h want run 1 strobes %h", bus.Run, strobes(), GRC | ROUT | ADD | ZIN); end
    tick();
    checks++; if (bus.Run !== 1'b1 || strobes() !== (ZLOW | GRA | RIN)) begin errors++; $display("FAIL stop_t5 run %b strobes %h want run 1", bus.Run, strobes()); end
    tick();
    checks++; if (bus.Run !== 1'b0) begin errors++; $display("FAIL stop_halt run %b want 0", bus.Run); end
    // Stop dropped before the boundary is ignored.
    go_t0(32'h1A9A_0000);
    tick(); tick(); tick();
    bus.Stop = 1'b1;
    tick();
    bus.Stop = 1'b0;
    tick(); tick();
    checks++; if (bus.Run !== 1'b1 || strobes() !== F0) begin errors++; $display("FAIL stop_pulse run %b strobes %h want run 1 strobes %h", bus.Run, strobes(), F0); end
  endtask

  task automatic test_clear_mid();
    go_t0(32'h1A9A_0000);
    tick(); tick(); tick(); tick();
    clr = 1'b1;
    tick();
    checks++; if (strobes() !== 42'd0 || bus.Run !== 1'b1) begin errors++; $display("FAIL clear_mid got %h run %b want 0 run 1", strobes(), bus.Run); end
    clr = 1'b0;
    tick();
    checks++; if (strobes() !== F0) begin errors++; $display("FAIL clear_mid_t0 got %h want %h", strobes(), F0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bus.IR = 32'h0; bus.Stop = 1'b0; bus.BranchOut = 1'b0;
    test_reset();
    test_add();
    test_addi();
    test_ld();
    test_br();
    test_mul();
    test_short();
    test_halt();
    test_stop();
    test_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer that sits directly upstream of the datapath. It observes the instruction register and the branch condition flag, steps through fetch/decode/execute micro-steps, and drives every datapath control strobe, one micro-step per clock. It owns the only instruction-level state in the processor: the step counter and the run/halt flag.

## Interface
- No parameters. Opcode and step encodings live in the package.
- Clock  in  1  system clock; all state changes on its rising edge
- Clear  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- BranchOut  in  1  CON flip-flop output from the datapath
- Stop  in  1  halt request; sampled only at instruction boundaries
- Run  out  1  high unless in HALT
- Clear_dp  out  1  copy of Clear, resets the datapath registers
- PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, Rout, RINout, OutPortOut  out  1 each  bus-source strobes
- PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin, Rin, RAin, CONin, OutPortIn  out  1 each  register-load strobes
- Gra, Grb, Grc  out  1 each  register-field selects
- Read, Write, IncPC  out  1 each  memory and PC-increment strobes
- ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT  out  1 each  ALU operation selects

## Operation
- States: RST, T0–T7, HALT. Outputs are a combinational (Moore) decode of the state and IR[31:27].
- Every output not listed for a step is 0.
- Clear=1 loads RST. In RST all strobes are 0 and Run=1. RST always advances to T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- Execute steps for each opcode. The final listed step returns to T0.
  - add 00011 … shl 01011, and/or/ror/rol/shr/shra as well: T3 Grb Rout Yin; T4 Grc Rout <op> Zin; T5 Zlowout Gra Rin.
  - addi 01100 / andi 01101 / ori 01110: same as the register ALU group, but T4 is Cout <op> Zin.
  - div 01111 / mul 10000: T3 Gra Rout Yin; T4 Grb Rout <op> Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10001 / not 10010: T3 Grb Rout <op> Zin; T4 Zlowout Gra Rin.
  - ld 00000: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3–T4 as ld; T5 Zlowout Gra Rin.
  - st 00010: T3–T5 as ld; T6 Gra Rout Write.
  - br 10011: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin, asserted only if BranchOut=1 (otherwise T6 is an empty step).
  - jr 10101: T3 Gra Rout PCin.
  - jal 10100: T3 PCout RAin; T4 Gra Rout PCin.
  - in 10110: T3 RINout Gra Rin.
  - out 10111: T3 Gra Rout OutPortIn.
  - mfhi 11000: T3 HIout Gra Rin.
  - mflo 11001: T3 LOout Gra Rin.
  - nop 11010: T3 only, no strobes.
  - halt 11011: T3 with no strobes, then HALT.
  - Any undefined opcode executes as nop.
- HALT:
  - All strobes are 0 and Run=0.
  - HALT is left only through Clear.
- Stop: if Stop=1 on the clock edge that ends an instruction's final step, the next state is HALT instead of T0.

## Timing
- One micro-step per cycle. Fetch takes 3 cycles.
- Total instruction length: ALU reg/imm 6; mul/div 7; ld 8; ldi 6; st 7; br 7; neg/not 5; jal 5; jr/in/out/mf*/nop 4.
- IR is valid from T3 onward. The decode must not depend on IR during T0–T2.
- BranchOut is loaded at the end of T3. It is consumed in T6 and must not be used earlier.
- Read and Write each last exactly one cycle. The RAM is combinational; MDRin samples it at the end of the same step.
- Clear has priority over all other events, including mid-instruction and in HALT. The cycle after Clear is asserted shows RST outputs.
- Stop asserted in a non-final step has no effect in that step. It is honoured only if still high at the instruction boundary.

## Structure
- minisrc_pkg contains:
  - 5-bit opcode localparams (OP_LD … OP_HALT)
  - step enum (RST, T0–T7, HALT)
  - an opcode-class function
- The datapath includes minisrc_pkg as well.
- Single module, with no sub-module: a next-state always block plus one combinational output-decode block.

## Test plan
- Reset: hold Clear 2 cycles, then release with IR=0 → RST outputs all 0; first released cycle is T0 with PCout=MARin=IncPC=Zin=1.
- add, IR=0x1A9A0000 (R5←R3+R4) → T3 Grb/Rout/Yin; T4 Grc/Rout/ADD/Zin; T5 Zlowout/Gra/Rin; T0 follows at cycle 6.
- ld, IR opcode 00000 → Read=1 only in T1 and T6; MDRout/Gra/Rin in T7; 8-cycle instruction.
- br: BranchOut=0 → no PCin in T6, next T0 at cycle 7. Repeat with BranchOut=1 → Zlowout=PCin=1 in T6.
- mul, opcode 10000 → LOin in T5 then HIin in T6, never both in the same cycle.
- halt, opcode 11011 → Run=0 from cycle 5 and stays low for 20 cycles; Clear returns to RST then T0. Repeat with Stop raised mid-add → HALT entered after T5.
